// File: rtl/ir_rx_nec.sv
// ir_rx_nec: NEC-format IR remote receiver. Times mark/space durations in
// prescaled ticks, validates them against fixed windows and publishes each
// good 32-bit frame or repeat code as a single-cycle pulse.
module ir_rx_nec #(
  parameter int unsigned TICK_DIV   = 1200,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          CHECK_INV  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic [31:0] frame_data,
  output logic        frame_valid,
  output logic        repeat_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DUR_W = 8;
  localparam int unsigned IDX_W = 5;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  // The edge cycle itself is the first cycle of the new interval.
  localparam logic [PRE_W-1:0] PRE_START = (TICK_DIV > 1) ? PRE_W'(1) : PRE_W'(0);
  localparam logic [DUR_W-1:0] DUR_START = (TICK_DIV > 1) ? DUR_W'(0) : DUR_W'(1);
  localparam logic [DUR_W-1:0] DUR_MAX   = DUR_W'(255);
  localparam logic [DUR_W-1:0] TIMEOUT   = DUR_W'(120);

  localparam logic [DUR_W-1:0] LM_LO = DUR_W'(80);
  localparam logic [DUR_W-1:0] LM_HI = DUR_W'(100);
  localparam logic [DUR_W-1:0] LS_LO = DUR_W'(40);
  localparam logic [DUR_W-1:0] LS_HI = DUR_W'(50);
  localparam logic [DUR_W-1:0] RS_LO = DUR_W'(18);
  localparam logic [DUR_W-1:0] RS_HI = DUR_W'(27);
  localparam logic [DUR_W-1:0] BM_LO = DUR_W'(3);
  localparam logic [DUR_W-1:0] BM_HI = DUR_W'(8);
  localparam logic [DUR_W-1:0] B0_LO = DUR_W'(3);
  localparam logic [DUR_W-1:0] B0_HI = DUR_W'(8);
  localparam logic [DUR_W-1:0] B1_LO = DUR_W'(13);
  localparam logic [DUR_W-1:0] B1_HI = DUR_W'(21);

  // Raw ir_in level while no carrier is present.
  localparam logic IDLE_LVL = ACTIVE_LOW;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_STOP
  } state_e;

  state_e             state, state_n;
  logic [1:0]         sync;
  logic               mark_r, mark_q;
  logic [PRE_W-1:0]   pre;
  logic [DUR_W-1:0]   dur;
  logic [IDX_W-1:0]   bit_idx, bit_idx_n;
  logic [31:0]        shreg, shreg_n;
  logic               has_frame, has_frame_n;
  logic [31:0]        frame_data_n;
  logic               valid_n, rep_n, err_n, busy_n;
  logic               edge_c, mark_start_c, mark_end_c, timeout_c, fail_c, bit_c;

  function automatic logic in_win(input logic [DUR_W-1:0] d,
                                  input logic [DUR_W-1:0] lo,
                                  input logic [DUR_W-1:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  assign edge_c       = mark_r ^ mark_q;
  assign mark_start_c = edge_c & mark_r;
  assign mark_end_c   = edge_c & ~mark_r;
  assign timeout_c    = (dur >= TIMEOUT) & ~edge_c;

  // Synchronize ir_in, normalize to mark polarity and keep a copy for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= {2{IDLE_LVL}};
      mark_r <= 1'b0;
      mark_q <= 1'b0;
    end else begin
      sync   <= {sync[0], ir_in};
      mark_r <= ACTIVE_LOW ? ~sync[1] : sync[1];
      mark_q <= mark_r;
    end
  end

  // Prescaler and saturating tick counter, restarted on every mark/space edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      dur <= '0;
    end else if (edge_c) begin
      pre <= PRE_START;
      dur <= DUR_START;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      if (dur != DUR_MAX) dur <= dur + DUR_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Next-state and output decode for the frame parser.
  always_comb begin
    state_n      = state;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    has_frame_n  = has_frame;
    frame_data_n = frame_data;
    valid_n      = 1'b0;
    rep_n        = 1'b0;
    err_n        = 1'b0;
    fail_c       = 1'b0;
    bit_c        = 1'b0;

    case (state)
      IDLE: begin
        if (mark_start_c) state_n = LEAD_MARK;
      end
      LEAD_MARK: begin
        if (mark_end_c) begin
          state_n = in_win(dur, LM_LO, LM_HI) ? LEAD_SPACE : IDLE;
        end else if (timeout_c) begin
          state_n = IDLE;
        end
      end
      LEAD_SPACE: begin
        if (mark_start_c) begin
          if (in_win(dur, LS_LO, LS_HI)) begin
            state_n   = BIT_MARK;
            bit_idx_n = '0;
            shreg_n   = '0;
          end else if (in_win(dur, RS_LO, RS_HI)) begin
            state_n = has_frame ? REP_STOP : IDLE;
          end else begin
            fail_c = 1'b1;
          end
        end else if (timeout_c) begin
          fail_c = 1'b1;
        end
      end
      BIT_MARK: begin
        if (mark_end_c) begin
          if (in_win(dur, BM_LO, BM_HI)) state_n = BIT_SPACE;
          else                           fail_c  = 1'b1;
        end else if (timeout_c) begin
          fail_c = 1'b1;
        end
      end
      BIT_SPACE: begin
        if (mark_start_c) begin
          if (in_win(dur, B0_LO, B0_HI) || in_win(dur, B1_LO, B1_HI)) begin
            bit_c            = in_win(dur, B1_LO, B1_HI);
            shreg_n[bit_idx] = bit_c;
            if (bit_idx == IDX_W'(31)) begin
              state_n = STOP_MARK;
            end else begin
              bit_idx_n = bit_idx + IDX_W'(1);
              state_n   = BIT_MARK;
            end
          end else begin
            fail_c = 1'b1;
          end
        end else if (timeout_c) begin
          fail_c = 1'b1;
        end
      end
      STOP_MARK: begin
        if (mark_end_c) begin
          if (in_win(dur, BM_LO, BM_HI) &&
              (!CHECK_INV || (shreg[31:24] == ~shreg[23:16]))) begin
            frame_data_n = shreg;
            valid_n      = 1'b1;
            has_frame_n  = 1'b1;
            state_n      = IDLE;
          end else begin
            fail_c = 1'b1;
          end
        end else if (timeout_c) begin
          fail_c = 1'b1;
        end
      end
      REP_STOP: begin
        if (mark_end_c) begin
          if (in_win(dur, BM_LO, BM_HI)) begin
            rep_n   = 1'b1;
            state_n = IDLE;
          end else begin
            fail_c = 1'b1;
          end
        end else if (timeout_c) begin
          fail_c = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (fail_c) begin
      err_n       = 1'b1;
      has_frame_n = 1'b0;
      state_n     = IDLE;
    end

    busy_n = (state_n != IDLE);
  end

  // FSM state, frame assembly and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_idx      <= '0;
      shreg        <= '0;
      has_frame    <= 1'b0;
      frame_data   <= '0;
      frame_valid  <= 1'b0;
      repeat_valid <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      bit_idx      <= bit_idx_n;
      shreg        <= shreg_n;
      has_frame    <= has_frame_n;
      frame_data   <= frame_data_n;
      frame_valid  <= valid_n;
      repeat_valid <= rep_n;
      frame_err    <= err_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_ir_rx_nec.sv
// tb_ir_rx_nec: table-driven frame/repeat vectors with a pulse scoreboard,
// plus hand-written timeout, glitch and mid-frame reset sequences.
module tb_ir_rx_nec;

  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_in;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        repeat_valid;
  logic        frame_err;
  logic        busy;

  always #5 clk = ~clk;

  ir_rx_nec #(.TICK_DIV(TD), .ACTIVE_LOW(1'b1), .CHECK_INV(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ir_in        (ir_in),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .repeat_valid (repeat_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  typedef enum logic [1:0] {K_NONE, K_VALID, K_REP, K_ERR} kind_e;
  typedef enum logic [1:0] {OP_FRAME, OP_REP, OP_BADLEAD} op_e;

  typedef struct {
    logic [31:0] data;
    kind_e       kind;
  } exp_t;

  typedef struct {
    op_e         op;
    logic [31:0] word;
    kind_e       kind;
    logic [31:0] data;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;
  int   hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input kind_e k, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Hold a level for a whole number of ticks; active-low: 0 = mark.
  task automatic level(input logic v, input int ticks);
    ir_in = v;
    repeat (ticks * TD) @(negedge clk);
  endtask

  task automatic mark(input int ticks);
    level(1'b0, ticks);
  endtask

  task automatic space(input int ticks);
    level(1'b1, ticks);
  endtask

  task automatic send_leader_bits(input logic [31:0] w, input int nbits);
    mark(90);
    space(45);
    for (int i = 0; i < nbits; i++) begin
      mark(5);
      space(w[i] ? 17 : 5);
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_leader_bits(w, 32);
    mark(5);
    space(2);
  endtask

  task automatic send_repeat();
    mark(90);
    space(22);
    mark(5);
    space(2);
  endtask

  task automatic send_badlead();
    mark(90);
    space(33);
    mark(5);
    space(2);
  endtask

  // Scoreboard: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    kind_e got;
    exp_t  e;
    if (!rst && (frame_valid || repeat_valid || frame_err)) begin
      check("pulse_onehot", 32'(frame_valid) + 32'(repeat_valid) + 32'(frame_err), 32'd1);
      got = frame_valid ? K_VALID : (repeat_valid ? K_REP : K_ERR);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=%0d required=none", got);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(got), 32'(e.kind));
        if (e.kind == K_VALID) check("pulse_data", frame_data, e.data);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{OP_REP,     32'h0,        K_NONE,  32'h0};
    vecs[1] = '{OP_FRAME,   32'hBA45FF00, K_VALID, 32'hBA45FF00};
    vecs[2] = '{OP_REP,     32'h0,        K_REP,   32'hBA45FF00};
    vecs[3] = '{OP_FRAME,   32'h0045FF00, K_ERR,   32'hBA45FF00};
    vecs[4] = '{OP_REP,     32'h0,        K_NONE,  32'hBA45FF00};
    vecs[5] = '{OP_FRAME,   32'hCB34ED12, K_VALID, 32'hCB34ED12};
    vecs[6] = '{OP_REP,     32'h0,        K_REP,   32'hCB34ED12};
    vecs[7] = '{OP_BADLEAD, 32'h0,        K_ERR,   32'hCB34ED12};
    vecs[8] = '{OP_REP,     32'h0,        K_NONE,  32'hCB34ED12};
    vecs[9] = '{OP_FRAME,   32'h00FF00FF, K_VALID, 32'h00FF00FF};

    rst   = 1'b1;
    ir_in = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_frame_data", frame_data, 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_repeat_valid", 32'(repeat_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    space(5);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].kind != K_NONE) push_exp(vecs[i].kind, vecs[i].word);
      case (vecs[i].op)
        OP_FRAME: send_frame(vecs[i].word);
        OP_REP:   send_repeat();
        default:  send_badlead();
      endcase
      space(30);
      check($sformatf("vec%0d_data", i), frame_data, vecs[i].data);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d_drain", i), 32'(exp_q.size()), 32'd0);
    end

    // Timeout while waiting for a bit's closing mark.
    push_exp(K_VALID, 32'hBA45FF00);
    send_frame(32'hBA45FF00);
    space(30);
    check("to_pre_data", frame_data, 32'hBA45FF00);
    push_exp(K_ERR, 32'h0);
    send_leader_bits(32'hBA45FF00, 9);
    mark(5);
    ir_in = 1'b1;
    hit   = 0;
    for (int j = 1; j <= 600 && hit == 0; j++) begin
      @(posedge clk);
      #1;
      if (frame_err) hit = j;
    end
    check("to_err_cycle", 32'(hit), 32'd484);
    @(negedge clk);
    check("to_busy", 32'(busy), 32'd0);
    space(20);
    send_repeat();
    space(30);
    check("to_rep_ignored", 32'(exp_q.size()), 32'd0);
    check("to_data_kept", frame_data, 32'hBA45FF00);

    // 20-tick glitch in IDLE, then a frame right behind it.
    ir_in = 1'b0;
    repeat (40) @(negedge clk);
    check("gl_busy_high", 32'(busy), 32'd1);
    repeat (40) @(negedge clk);
    space(5);
    check("gl_busy_low", 32'(busy), 32'd0);
    check("gl_no_pulse", 32'(exp_q.size()), 32'd0);
    push_exp(K_VALID, 32'hFF0000FF);
    send_frame(32'hFF0000FF);
    space(30);
    check("gl_frame_data", frame_data, 32'hFF0000FF);

    // Reset during bit 16, then a clean frame.
    send_leader_bits(32'hCB34ED12, 16);
    mark(5);
    space(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_frame_data", frame_data, 32'h0);
    check("mr_frame_valid", 32'(frame_valid), 32'd0);
    check("mr_repeat_valid", 32'(repeat_valid), 32'd0);
    check("mr_frame_err", 32'(frame_err), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    space(10);
    push_exp(K_VALID, 32'hCB34ED12);
    send_frame(32'hCB34ED12);
    space(30);
    check("mr_after_data", frame_data, 32'hCB34ED12);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
